// File: rtl/mips_ctrl_pkg.sv
// Shared constants and types for the multi-cycle MIPS controller:
// opcode/function fields, FSM state encoding, datapath select encodings
// and the one-hot instruction class consumed by the FSM.
package mips_ctrl_pkg;

   // Opcode field values
   localparam logic [5:0] OP_R   = 6'b000000;
   localparam logic [5:0] OP_ORI = 6'b001101;
   localparam logic [5:0] OP_LW  = 6'b100011;
   localparam logic [5:0] OP_SW  = 6'b101011;
   localparam logic [5:0] OP_BEQ = 6'b000100;
   localparam logic [5:0] OP_LUI = 6'b001111;
   localparam logic [5:0] OP_JAL = 6'b000011;

   // R-type function field values
   localparam logic [5:0] FN_NOP = 6'b000000;
   localparam logic [5:0] FN_ADD = 6'b100000;
   localparam logic [5:0] FN_SUB = 6'b100010;
   localparam logic [5:0] FN_JR  = 6'b001000;

   // Controller states; the numeric values are visible on the debug port
   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_FETCH  = 3'd1,
      ST_DECODE = 3'd2,
      ST_EXEC   = 3'd3,
      ST_MEM    = 3'd4,
      ST_WB     = 3'd5
   } ctrl_state_t;

   // ALU operation codes (other codes reserved)
   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_OR  = 3'b011;

   // PC source select
   localparam logic [1:0] PC_PLUS4  = 2'd0;
   localparam logic [1:0] PC_GPR    = 2'd1;
   localparam logic [1:0] PC_JAL    = 2'd2;
   localparam logic [1:0] PC_BRANCH = 2'd3;

   // Destination register select
   localparam logic [1:0] RD_RT = 2'd0;
   localparam logic [1:0] RD_RD = 2'd1;
   localparam logic [1:0] RD_RA = 2'd2;

   // Write-back source select
   localparam logic [1:0] WB_ALU  = 2'd0;
   localparam logic [1:0] WB_MEM  = 2'd1;
   localparam logic [1:0] WB_IMM  = 2'd2;
   localparam logic [1:0] WB_LINK = 2'd3;

   // One-hot instruction class; all zero means unsupported encoding
   typedef struct packed {
      logic isAdd;
      logic isSub;
      logic isJr;
      logic isNop;
      logic isOri;
      logic isLw;
      logic isSw;
      logic isBeq;
      logic isLui;
      logic isJal;
   } instr_class_t;

   // Instructions that write a GPR through the WB state
   function automatic logic needsWb(input instr_class_t c);
      return c.isAdd | c.isSub | c.isOri | c.isLui;
   endfunction

endpackage

// File: rtl/mc_ctrl_fsm_if.sv
// Controller-to-datapath/memory bundle. The master side is the controller,
// the slave side is the datapath plus instruction/data memories.
interface mc_ctrl_fsm_if #(
   parameter int ALUOP_W = 3,
   parameter int PCSRC_W = 2
);
   logic [5:0]         op;
   logic [5:0]         func;
   logic               alu_zero;
   logic               imem_ready;
   logic               dmem_ready;
   logic               stall;
   logic               imem_req;
   logic               dmem_req;
   logic               mem_write;
   logic               ir_write;
   logic               pc_write;
   logic [PCSRC_W-1:0] pc_src;
   logic               reg_write;
   logic [1:0]         reg_dst;
   logic [1:0]         wb_src;
   logic               alu_src_b;
   logic               ext_zero;
   logic [ALUOP_W-1:0] alu_op;
   logic               instr_done;
   logic               illegal_instr;
   logic [2:0]         state;

   modport master (
      input  op, func, alu_zero, imem_ready, dmem_ready, stall,
      output imem_req, dmem_req, mem_write, ir_write, pc_write, pc_src,
             reg_write, reg_dst, wb_src, alu_src_b, ext_zero, alu_op,
             instr_done, illegal_instr, state
   );

   modport slave (
      output op, func, alu_zero, imem_ready, dmem_ready, stall,
      input  imem_req, dmem_req, mem_write, ir_write, pc_write, pc_src,
             reg_write, reg_dst, wb_src, alu_src_b, ext_zero, alu_op,
             instr_done, illegal_instr, state
   );
endinterface

// File: rtl/mips_instr_class.sv
// Combinational opcode/function decoder: maps the IR fields onto a one-hot
// instruction class and flags anything outside the supported subset.
module mips_instr_class
   import mips_ctrl_pkg::*;
(
   input  logic [5:0]   op,
   input  logic [5:0]   func,
   output instr_class_t iClass,
   output logic         illegal
);

   // Decode op first, then func for R-type encodings
   always_comb begin
      iClass  = '0;
      illegal = 1'b0;
      case (op)
         OP_R: begin
            case (func)
               FN_NOP:  iClass.isNop = 1'b1;
               FN_ADD:  iClass.isAdd = 1'b1;
               FN_SUB:  iClass.isSub = 1'b1;
               FN_JR:   iClass.isJr  = 1'b1;
               default: illegal      = 1'b1;
            endcase
         end
         OP_ORI:  iClass.isOri = 1'b1;
         OP_LW:   iClass.isLw  = 1'b1;
         OP_SW:   iClass.isSw  = 1'b1;
         OP_BEQ:  iClass.isBeq = 1'b1;
         OP_LUI:  iClass.isLui = 1'b1;
         OP_JAL:  iClass.isJal = 1'b1;
         default: illegal      = 1'b1;
      endcase
   end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle MIPS controller. Sequences each instruction through
// FETCH/DECODE/EXEC/MEM/WB with ready handshakes to instruction and data
// memory, a freeze (stall) input and illegal-opcode reporting. Outputs are
// a decode of the current state plus the instruction class and handshake
// inputs, so they respond within the same cycle as ready/alu_zero/stall.
module mc_ctrl_fsm
   import mips_ctrl_pkg::*;
#(
   parameter int ALUOP_W  = 3,
   parameter int PCSRC_W  = 2,
   parameter bit NOP_FAST = 1'b1
) (
   input  logic             clk,
   input  logic             rst_n,
   mc_ctrl_fsm_if.master    bus
);

   ctrl_state_t  curState;
   instr_class_t iClass;
   logic         illegal;
   logic         retireInDecode;
   logic         stallNow;

   mips_instr_class uClass (
      .op      (bus.op),
      .func    (bus.func),
      .iClass  (iClass),
      .illegal (illegal)
   );

   assign stallNow = bus.stall;

   // jal/jr always finish in DECODE; nop/illegal do so only on the fast path
   assign retireInDecode = iClass.isJal | iClass.isJr |
                           (NOP_FAST & (iClass.isNop | illegal));

   // State register: stall freezes the sequence, reset wins over everything
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         curState <= ST_IDLE;
      end else if (!stallNow) begin
         case (curState)
            ST_IDLE:   curState <= ST_FETCH;
            ST_FETCH:  if (bus.imem_ready) curState <= ST_DECODE;
            ST_DECODE: curState <= retireInDecode ? ST_FETCH : ST_EXEC;
            ST_EXEC: begin
               if (needsWb(iClass))               curState <= ST_WB;
               else if (iClass.isLw | iClass.isSw) curState <= ST_MEM;
               else                                curState <= ST_FETCH;
            end
            ST_MEM: begin
               if (bus.dmem_ready) curState <= iClass.isLw ? ST_WB : ST_FETCH;
            end
            ST_WB:     curState <= ST_FETCH;
            default:   curState <= ST_IDLE;
         endcase
      end
   end

   // Output decode: per-state controls, then the stall mask on write enables
   always_comb begin
      bus.imem_req      = 1'b0;
      bus.dmem_req      = 1'b0;
      bus.mem_write     = 1'b0;
      bus.ir_write      = 1'b0;
      bus.pc_write      = 1'b0;
      bus.pc_src        = PCSRC_W'(PC_PLUS4);
      bus.reg_write     = 1'b0;
      bus.reg_dst       = RD_RT;
      bus.wb_src        = WB_ALU;
      bus.alu_src_b     = 1'b0;
      bus.ext_zero      = 1'b0;
      bus.alu_op        = ALUOP_W'(ALU_ADD);
      bus.instr_done    = 1'b0;
      bus.illegal_instr = 1'b0;

      case (curState)
         ST_FETCH: begin
            bus.imem_req = 1'b1;
            if (bus.imem_ready) begin
               bus.ir_write = 1'b1;
               bus.pc_write = 1'b1;
            end
         end
         ST_DECODE: begin
            if (iClass.isJal) begin
               bus.pc_write   = 1'b1;
               bus.pc_src     = PCSRC_W'(PC_JAL);
               bus.reg_write  = 1'b1;
               bus.reg_dst    = RD_RA;
               bus.wb_src     = WB_LINK;
               bus.instr_done = 1'b1;
            end else if (iClass.isJr) begin
               bus.pc_write   = 1'b1;
               bus.pc_src     = PCSRC_W'(PC_GPR);
               bus.instr_done = 1'b1;
            end else if (retireInDecode) begin
               bus.instr_done = 1'b1;
            end
            // Held off while frozen so the report stays a single pulse
            bus.illegal_instr = illegal & ~stallNow;
         end
         ST_EXEC: begin
            if (iClass.isAdd) begin
               bus.alu_op = ALUOP_W'(ALU_ADD);
            end else if (iClass.isSub) begin
               bus.alu_op = ALUOP_W'(ALU_SUB);
            end else if (iClass.isOri) begin
               bus.alu_src_b = 1'b1;
               bus.ext_zero  = 1'b1;
               bus.alu_op    = ALUOP_W'(ALU_OR);
            end else if (iClass.isLw | iClass.isSw) begin
               bus.alu_src_b = 1'b1;
               bus.alu_op    = ALUOP_W'(ALU_ADD);
            end else if (iClass.isBeq) begin
               bus.alu_op     = ALUOP_W'(ALU_SUB);
               bus.pc_src     = PCSRC_W'(PC_BRANCH);
               bus.pc_write   = bus.alu_zero;
               bus.instr_done = 1'b1;
            end else if (!iClass.isLui) begin
               // Slow-path nop/illegal: retire here with no side effects
               bus.instr_done = 1'b1;
            end
         end
         ST_MEM: begin
            bus.dmem_req  = 1'b1;
            bus.mem_write = iClass.isSw;
            if (iClass.isSw && bus.dmem_ready) bus.instr_done = 1'b1;
         end
         ST_WB: begin
            bus.reg_write  = 1'b1;
            bus.instr_done = 1'b1;
            if (iClass.isAdd | iClass.isSub) begin
               bus.reg_dst = RD_RD;
               bus.wb_src  = WB_ALU;
            end else if (iClass.isLw) begin
               bus.wb_src  = WB_MEM;
            end else if (iClass.isLui) begin
               bus.wb_src  = WB_IMM;
            end
         end
         default: ;
      endcase

      // Freeze: no architectural updates; requests stay asserted
      if (stallNow) begin
         bus.pc_write   = 1'b0;
         bus.ir_write   = 1'b0;
         bus.reg_write  = 1'b0;
         bus.mem_write  = 1'b0;
         bus.instr_done = 1'b0;
      end
   end

   assign bus.state = curState;

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Directed bench for mc_ctrl_fsm: the stimulus process queues a hand-written
// expected output vector for every cycle it drives; a monitor pops and
// compares on the falling edge.
module tb_mc_ctrl_fsm;

   typedef struct packed {
      logic [2:0] state;
      logic       imem_req;
      logic       dmem_req;
      logic       mem_write;
      logic       ir_write;
      logic       pc_write;
      logic [1:0] pc_src;
      logic       reg_write;
      logic [1:0] reg_dst;
      logic [1:0] wb_src;
      logic       alu_src_b;
      logic       ext_zero;
      logic [2:0] alu_op;
      logic       instr_done;
      logic       illegal_instr;
   } exp_t;

   localparam exp_t E_IDLE   = '0;
   localparam exp_t E_FETCH  = '{state: 3'd1, imem_req: 1'b1, ir_write: 1'b1, pc_write: 1'b1, default: '0};
   localparam exp_t E_FWAIT  = '{state: 3'd1, imem_req: 1'b1, default: '0};
   localparam exp_t E_DEC    = '{state: 3'd2, default: '0};
   localparam exp_t E_DDONE  = '{state: 3'd2, instr_done: 1'b1, default: '0};
   localparam exp_t E_EXRR   = '{state: 3'd3, default: '0};
   localparam exp_t E_EXMEM  = '{state: 3'd3, alu_src_b: 1'b1, default: '0};

   logic clk;
   logic rst_n;
   int   checks;
   int   errors;
   exp_t expQ[$];
   string nameQ[$];

   mc_ctrl_fsm_if #(.ALUOP_W(3), .PCSRC_W(2)) bus ();

   mc_ctrl_fsm #(.ALUOP_W(3), .PCSRC_W(2), .NOP_FAST(1'b1)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Queue this cycle's expectation, then advance to just after the next edge
   task automatic cyc(input exp_t e, input string nm);
      expQ.push_back(e);
      nameQ.push_back(nm);
      @(posedge clk);
      #1;
   endtask

   task automatic setInstr(input logic [5:0] o, input logic [5:0] f);
      bus.op   = o;
      bus.func = f;
   endtask

   // Monitor: compare DUT outputs against the oldest queued expectation
   always @(negedge clk) begin
      exp_t  act;
      exp_t  e;
      string nm;
      if (expQ.size() > 0) begin
         e  = expQ.pop_front();
         nm = nameQ.pop_front();
         act.state         = bus.state;
         act.imem_req      = bus.imem_req;
         act.dmem_req      = bus.dmem_req;
         act.mem_write     = bus.mem_write;
         act.ir_write      = bus.ir_write;
         act.pc_write      = bus.pc_write;
         act.pc_src        = bus.pc_src;
         act.reg_write     = bus.reg_write;
         act.reg_dst       = bus.reg_dst;
         act.wb_src        = bus.wb_src;
         act.alu_src_b     = bus.alu_src_b;
         act.ext_zero      = bus.ext_zero;
         act.alu_op        = bus.alu_op;
         act.instr_done    = bus.instr_done;
         act.illegal_instr = bus.illegal_instr;
         checks++;
         if (act !== e) begin
            errors++;
            $display("FAIL %s: got %06h (state %0d) expected %06h (state %0d)",
                     nm, act, act.state, e, e.state);
         end
      end
   end

   initial begin
      checks = 0;
      errors = 0;
      rst_n  = 1'b1;
      bus.op = 6'd0;
      bus.func = 6'd0;
      bus.alu_zero = 1'b0;
      bus.imem_ready = 1'b0;
      bus.dmem_ready = 1'b0;
      bus.stall = 1'b0;
      #2 rst_n = 1'b0;
      @(posedge clk);
      #1;

      cyc(E_IDLE, "reset_idle");
      rst_n = 1'b1;
      cyc(E_IDLE, "idle_after_release");

      // add, readies high: 4 cycles
      bus.imem_ready = 1'b1;
      bus.dmem_ready = 1'b1;
      setInstr(6'b000000, 6'b100000);
      cyc(E_FETCH, "add_fetch");
      cyc(E_DEC,   "add_decode");
      cyc(E_EXRR,  "add_exec");
      cyc('{state: 3'd5, reg_write: 1'b1, reg_dst: 2'd1, instr_done: 1'b1, default: '0}, "add_wb");

      // sub
      setInstr(6'b000000, 6'b100010);
      cyc(E_FETCH, "sub_fetch");
      cyc(E_DEC,   "sub_decode");
      cyc('{state: 3'd3, alu_op: 3'b001, default: '0}, "sub_exec");
      cyc('{state: 3'd5, reg_write: 1'b1, reg_dst: 2'd1, instr_done: 1'b1, default: '0}, "sub_wb");

      // lw with dmem_ready low for three MEM cycles: 8 cycles
      setInstr(6'b100011, 6'b000000);
      cyc(E_FETCH, "lw_fetch");
      cyc(E_DEC,   "lw_decode");
      bus.dmem_ready = 1'b0;
      cyc(E_EXMEM, "lw_exec");
      for (int i = 0; i < 3; i++)
         cyc('{state: 3'd4, dmem_req: 1'b1, default: '0}, "lw_mem_wait");
      bus.dmem_ready = 1'b1;
      cyc('{state: 3'd4, dmem_req: 1'b1, default: '0}, "lw_mem_ready");
      cyc('{state: 3'd5, reg_write: 1'b1, wb_src: 2'd1, instr_done: 1'b1, default: '0}, "lw_wb");

      // sw
      setInstr(6'b101011, 6'b000000);
      cyc(E_FETCH, "sw_fetch");
      cyc(E_DEC,   "sw_decode");
      cyc(E_EXMEM, "sw_exec");
      cyc('{state: 3'd4, dmem_req: 1'b1, mem_write: 1'b1, instr_done: 1'b1, default: '0}, "sw_mem");

      // ori
      setInstr(6'b001101, 6'b000000);
      cyc(E_FETCH, "ori_fetch");
      cyc(E_DEC,   "ori_decode");
      cyc('{state: 3'd3, alu_src_b: 1'b1, ext_zero: 1'b1, alu_op: 3'b011, default: '0}, "ori_exec");
      cyc('{state: 3'd5, reg_write: 1'b1, instr_done: 1'b1, default: '0}, "ori_wb");

      // lui
      setInstr(6'b001111, 6'b000000);
      cyc(E_FETCH, "lui_fetch");
      cyc(E_DEC,   "lui_decode");
      cyc(E_EXRR,  "lui_exec");
      cyc('{state: 3'd5, reg_write: 1'b1, wb_src: 2'd2, instr_done: 1'b1, default: '0}, "lui_wb");

      // beq taken, then not taken
      setInstr(6'b000100, 6'b000000);
      bus.alu_zero = 1'b1;
      cyc(E_FETCH, "beq_t_fetch");
      cyc(E_DEC,   "beq_t_decode");
      cyc('{state: 3'd3, pc_write: 1'b1, pc_src: 2'd3, alu_op: 3'b001, instr_done: 1'b1, default: '0}, "beq_t_exec");
      bus.alu_zero = 1'b0;
      cyc(E_FETCH, "beq_n_fetch");
      cyc(E_DEC,   "beq_n_decode");
      cyc('{state: 3'd3, pc_src: 2'd3, alu_op: 3'b001, instr_done: 1'b1, default: '0}, "beq_n_exec");

      // jal, then jr
      setInstr(6'b000011, 6'b000000);
      cyc(E_FETCH, "jal_fetch");
      cyc('{state: 3'd2, pc_write: 1'b1, pc_src: 2'd2, reg_write: 1'b1, reg_dst: 2'd2, wb_src: 2'd3, instr_done: 1'b1, default: '0}, "jal_decode");
      setInstr(6'b000000, 6'b001000);
      cyc(E_FETCH, "jr_fetch");
      cyc('{state: 3'd2, pc_write: 1'b1, pc_src: 2'd1, instr_done: 1'b1, default: '0}, "jr_decode");

      // illegal opcode
      setInstr(6'b111111, 6'b000000);
      cyc(E_FETCH, "ill_fetch");
      cyc('{state: 3'd2, instr_done: 1'b1, illegal_instr: 1'b1, default: '0}, "ill_decode");

      // imem not ready for one cycle
      setInstr(6'b000000, 6'b000000);
      bus.imem_ready = 1'b0;
      cyc(E_FWAIT, "fetch_wait");
      bus.imem_ready = 1'b1;
      cyc(E_FETCH, "nop_fetch");
      cyc(E_DDONE, "nop_decode");

      // stall during FETCH with imem_ready high
      bus.stall = 1'b1;
      cyc(E_FWAIT, "stall_fetch_1");
      cyc(E_FWAIT, "stall_fetch_2");
      bus.stall = 1'b0;
      cyc(E_FETCH, "stall_release_fetch");
      cyc(E_DDONE, "stall_nop_decode");

      // asynchronous reset in the middle of MEM
      setInstr(6'b100011, 6'b000000);
      cyc(E_FETCH, "rst_lw_fetch");
      cyc(E_DEC,   "rst_lw_decode");
      bus.dmem_ready = 1'b0;
      cyc(E_EXMEM, "rst_lw_exec");
      cyc('{state: 3'd4, dmem_req: 1'b1, default: '0}, "rst_lw_mem");
      rst_n = 1'b0;
      cyc(E_IDLE, "rst_mid_mem");
      rst_n = 1'b1;
      cyc(E_IDLE, "idle_after_rst");
      cyc(E_FETCH, "fetch_after_rst");

      // Every queued expectation must have been consumed
      @(posedge clk);
      #1;
      if (expQ.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL drain: %0d expectations left, required 0", expQ.size());
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
